io_responder: RTL and testbench
===============================

# io_responder

Memory-mapped I/O responder on the processor's I/O bus: decodes processor read/write requests in a 4-word window and answers each with a one-cycle acknowledge. It buffers words arriving from an external device in an RX FIFO and drives a single-entry output port toward the device. A level interrupt request tells the processor that input data is waiting.

## Interface
- DEPTH, 4: RX FIFO depth in words; power of 2, ≥2.
- BASE_ADDR, 16'hFF00: window base; bits [1:0] must be 0.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  processor access request, held high until ack seen
- we  in  1  1 = write, 0 = read; stable while req high
- addr  in  16  word address; stable while req high
- wdata  in  16  write data; stable while req high
- rdata  out  16  read data, valid only while ack high
- ack  out  1  one-cycle completion pulse
- dev_valid  in  1  device offers dev_data
- dev_data  in  16  device word
- dev_ready  out  1  RX FIFO can accept a word
- out_data  out  16  word presented to device
- out_valid  out  1  out_data pending
- out_ready  in  1  device consumes out_data
- irq  out  1  interrupt request, level

## Operation
- Hit: req high and addr[15:2] == BASE_ADDR[15:2]. A miss is ignored: no ack and no state change.
- Register map, selected by addr[1:0]:
  - 0 DATA_IN: a read pops the FIFO head. If the FIFO is empty, the read returns 0 and does not pop. A write is acked and ignored.
  - 1 DATA_OUT: a write loads out_data and sets out_valid. A read returns the last written value.
  - 2 STATUS: a read returns {11'b0, timeout, irq_en, out_valid, full, !empty}. On a write, wdata[3] loads irq_en, and wdata[4] = 1 clears timeout.
  - 3 COUNT: a read returns the FIFO occupancy, zero-extended. A write is ignored.
- FSM states: IDLE, WAIT_OUT, ACK, RELEASE.
  - IDLE → ACK on a hit, except a DATA_OUT write while out_valid = 1, which goes IDLE → WAIT_OUT.
  - WAIT_OUT → ACK in the cycle out_ready is seen high, i.e. the old word is consumed. The new word loads on that same edge.
  - ACK drives ack = 1 for exactly one cycle and commits the access (pop, register write), then → RELEASE.
  - RELEASE → IDLE once req is low. A request is never acked twice.
- Output port: out_valid clears on any edge with out_valid & out_ready, unless a DATA_OUT write loads on that same edge.
- RX FIFO:
  - dev_ready = !full, registered.
  - A push occurs when dev_valid & dev_ready. Push and pop in the same cycle are both performed and the count is unchanged.
  - When full, dev_ready stays low even during a pop cycle; it rises the next cycle.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- irq is registered irq_en & !empty and drops the cycle after the pop that empties the FIFO.
- Reset values:
  - ack = 0, rdata = 0, out_valid = 0, out_data = 0.
  - dev_ready = 1, irq = 0, irq_en = 0, timeout = 0.
  - FIFO empty, FSM IDLE.
- A reset asserted mid-access aborts the access with no ack. The processor must reissue it.

## Timing
- A hit sampled in IDLE at edge N gives ack and rdata high during cycle N+1, so latency is 1 cycle. The minimum repeat is 3 cycles per access.
- In WAIT_OUT, ack comes 1 cycle after the edge where out_ready is sampled high.
- FIFO push to !empty in STATUS: visible 1 cycle later. Push to irq: also 1 cycle.
- There is no combinational path from req/addr to ack, or from dev_valid to dev_ready.

## Configuration
- IO_RESPONDER_TIMEOUT_EN defined:
  - WAIT_OUT runs an 8-bit counter that clears on entry.
  - If it reaches 255 without out_ready, the FSM goes to ACK, the write is dropped, and STATUS.timeout sets. timeout is sticky.
- Undefined: WAIT_OUT waits indefinitely, and STATUS bit 4 reads 0.

## Test plan
- Reset with dev_valid held high: dev_ready = 1, irq = 0, rdata = 0. After release, 4 pushes of 16'h0011..16'h0014 → COUNT reads 4, dev_ready = 0, STATUS = 16'h0003.
- Write STATUS 16'h0008, push 16'hBEEF → irq high 1 cycle after the push. A DATA_IN read returns 16'hBEEF with ack in the cycle after req, and irq drops the cycle after.
- DATA_IN read on an empty FIFO → rdata 0, COUNT still 0, exactly one ack pulse while req is held 5 cycles.
- Write DATA_OUT 16'h1234 with out_ready = 0, then write 16'h5678 → the second ack is held until out_ready rises, then out_data = 16'h5678 and out_valid = 1.
- Access to addr 16'hFE00 → no ack for 20 cycles, and no register changes.
- With IO_RESPONDER_TIMEOUT_EN defined, out_ready is held 0 → the second DATA_OUT write is acked 256 cycles after WAIT_OUT entry, STATUS bit 4 = 1, and out_data keeps 16'h1234.

Source files
------------

// File: rtl/io_responder.sv
// io_responder: 4-word memory-mapped I/O responder with an RX FIFO, a single-entry output port and a level irq.
// Optional WAIT_OUT timeout is enabled by defining IO_RESPONDER_TIMEOUT_EN.
module io_responder #(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    input  logic        dev_valid,
    input  logic [15:0] dev_data,
    output logic        dev_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OUT,
        ACK,
        RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic          skip_q, skip_d;
    logic [15:0]   rdata_q, rdata_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;
    logic          dev_ready_q, dev_ready_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   mem_q [DEPTH];

    logic          hit, empty, full, push, pop, load_out, timeout;
    logic          wr_status;
    logic [15:0]   read_val;

    assign hit       = req && (addr[15:2] == BASE_ADDR[15:2]);
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign push      = dev_valid && dev_ready_q;
    assign pop       = (state_q == ACK) && !we && (addr[1:0] == 2'd0) && !empty;
    assign wr_status = (state_q == ACK) && we && (addr[1:0] == 2'd2);
    // A write that passed through WAIT_OUT already loaded (or was dropped) on the way into ACK.
    assign load_out  = ((state_q == WAIT_OUT) && out_ready) ||
                       ((state_q == ACK) && !skip_q && we && (addr[1:0] == 2'd1));

`ifdef IO_RESPONDER_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;
    logic       timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == WAIT_OUT) tmo_cnt_q <= tmo_cnt_q + 8'd1;
            else                     tmo_cnt_q <= '0;
            if ((state_q == WAIT_OUT) && !out_ready && (tmo_cnt_q == '1)) timeout_q <= 1'b1;
            else if (wr_status && wdata[4])                                timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        read_val = '0;
        case (addr[1:0])
            2'd0:    read_val = empty ? 16'h0000 : mem_q[rd_ptr_q];
            2'd1:    read_val = out_data_q;
            2'd2:    read_val = {11'b0, timeout, irq_en_q, out_valid_q, full, !empty};
            default: read_val = 16'(count_q);
        endcase
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (we && (addr[1:0] == 2'd1) && out_valid_q) begin
                        state_d = WAIT_OUT;
                        skip_d  = 1'b1;
                    end else begin
                        state_d = ACK;
                        skip_d  = 1'b0;
                        if (!we) rdata_d = read_val;
                    end
                end
            end
            WAIT_OUT: begin
                if (out_ready) state_d = ACK;
`ifdef IO_RESPONDER_TIMEOUT_EN
                else if (tmo_cnt_q == '1) state_d = ACK;
`endif
            end
            ACK:     state_d = RELEASE;
            RELEASE: if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        irq_en_d    = irq_en_q;
        count_d     = count_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (load_out) begin
            out_data_d  = wdata;
            out_valid_d = 1'b1;
        end
        if (wr_status) irq_en_d = wdata[3];
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        dev_ready_d = (count_d != FULL_CNT);
        irq_d       = irq_en_d && (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skip_q      <= 1'b0;
            rdata_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
            dev_ready_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            rdata_q     <= rdata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
            dev_ready_q <= dev_ready_d;
            count_q     <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dev_data;
    end

    assign ack       = (state_q == ACK);
    assign rdata     = rdata_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign dev_ready = dev_ready_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register-access vector table plus hand sequences for irq, WAIT_OUT, misses and FIFO wrap.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [15:0] addr, wdata, rdata;
    logic        ack;
    logic        dev_valid;
    logic [15:0] dev_data;
    logic        dev_ready;
    logic [15:0] out_data;
    logic        out_valid, out_ready;
    logic        irq;

    int passed = 0;
    int total  = 0;

    io_responder #(.DEPTH(4), .BASE_ADDR(16'hFF00)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .dev_valid(dev_valid), .dev_data(dev_data),
        .dev_ready(dev_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full bus access; returns rdata seen with ack and the ack latency in cycles (0 = never acked).
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0; rd = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ack) begin
                lat = i;
                rd  = rdata;
                break;
            end
        end
        req = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [15:0] exp, input string name);
        logic [15:0] rd;
        int          lat;
        access(1'b0, a, 16'h0000, rd, lat);
        chk({name, "_lat"}, lat, 1);
        chk(name, rd, exp);
    endtask

    task automatic wr_do(input logic [15:0] a, input logic [15:0] d, input string name);
        logic [15:0] rd;
        int          lat;
        access(1'b1, a, d, rd, lat);
        chk({name, "_lat"}, lat, 1);
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] got;
        int          lat;
        int          acks;
        logic [15:0] miss_addr [2];

        vecs[0]  = '{1'b0, 16'hFF03, 16'h0000, 16'h0004, "count_full"};
        vecs[1]  = '{1'b0, 16'hFF02, 16'h0000, 16'h0003, "status_full"};
        vecs[2]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0011, "pop_0011"};
        vecs[3]  = '{1'b0, 16'hFF03, 16'h0000, 16'h0003, "count_3"};
        vecs[4]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0012, "pop_0012"};
        vecs[5]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0013, "pop_0013"};
        vecs[6]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0014, "pop_0014"};
        vecs[7]  = '{1'b0, 16'hFF00, 16'h0000, 16'h0000, "pop_empty"};
        vecs[8]  = '{1'b0, 16'hFF02, 16'h0000, 16'h0000, "status_empty"};
        vecs[9]  = '{1'b1, 16'hFF03, 16'hFFFF, 16'h0000, "wr_count_ign"};
        vecs[10] = '{1'b1, 16'hFF00, 16'h5555, 16'h0000, "wr_datain_ign"};
        vecs[11] = '{1'b0, 16'hFF03, 16'h0000, 16'h0000, "count_0"};
        miss_addr[0] = 16'hFE00;
        miss_addr[1] = 16'hFE02;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        dev_valid = 1'b1; dev_data = 16'h0011; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_dev_ready", dev_ready, 1);
        chk("rst_irq", irq, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dev_data = 16'h0011 + 16'(i);
            tick();
        end
        dev_valid = 1'b0;
        chk("full_dev_ready", dev_ready, 0);
        chk("full_irq_masked", irq, 0);

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            chk({vecs[i].name, "_lat"}, lat, 1);
            if (!vecs[i].we) chk(vecs[i].name, rd, vecs[i].exp);
        end

        wr_do(16'hFF02, 16'h0008, "wr_irq_en");
        chk("irq_empty", irq, 0);
        dev_valid = 1'b1; dev_data = 16'hBEEF;
        tick();
        dev_valid = 1'b0;
        chk("irq_after_push", irq, 1);
        req = 1'b1; we = 1'b0; addr = 16'hFF00;
        tick();
        chk("beef_ack", ack, 1);
        chk("beef_rdata", rdata, 16'hBEEF);
        chk("irq_during_ack", irq, 1);
        req = 1'b0;
        tick();
        chk("irq_after_pop", irq, 0);
        chk("ack_single", ack, 0);
        tick();

        req = 1'b1; we = 1'b0; addr = 16'hFF00;
        acks = 0; got = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack) begin
                acks++;
                got = rdata;
            end
        end
        req = 1'b0;
        tick();
        tick();
        chk("held_req_acks", acks, 1);
        chk("held_req_rdata", got, 0);
        rd_chk(16'hFF03, 16'h0000, "count_after_empty_rd");

        wr_do(16'hFF01, 16'h1234, "wr_out_1234");
        chk("out_valid_1234", out_valid, 1);
        chk("out_data_1234", out_data, 16'h1234);
        req = 1'b1; we = 1'b1; addr = 16'hFF01; wdata = 16'h5678;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack) acks++;
        end
        chk("wait_out_no_ack", acks, 0);
        chk("wait_out_data_kept", out_data, 16'h1234);
        out_ready = 1'b1;
        tick();
        chk("wait_out_ack", ack, 1);
        chk("out_data_5678", out_data, 16'h5678);
        chk("out_valid_5678", out_valid, 1);
        out_ready = 1'b0; req = 1'b0;
        tick();
        tick();
        chk("out_valid_held", out_valid, 1);
        rd_chk(16'hFF01, 16'h5678, "rd_data_out");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_consumed", out_valid, 0);

        for (int m = 0; m < 2; m++) begin
            req = 1'b1; we = miss_addr[m][1]; addr = miss_addr[m]; wdata = 16'h0000;
            acks = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (ack) acks++;
            end
            req = 1'b0;
            tick();
            chk("miss_no_ack", acks, 0);
        end
        rd_chk(16'hFF02, 16'h0008, "status_after_miss");

        dev_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dev_data = 16'h0020 + 16'(i);
            tick();
        end
        dev_valid = 1'b0;
        chk("refill_dev_ready", dev_ready, 0);
        req = 1'b1; we = 1'b0; addr = 16'hFF00;
        tick();
        chk("full_pop_ack", ack, 1);
        chk("full_pop_rdata", rdata, 16'h0020);
        chk("ready_low_in_pop", dev_ready, 0);
        req = 1'b0;
        tick();
        chk("ready_after_pop", dev_ready, 1);
        tick();
        for (int i = 1; i < 4; i++) rd_chk(16'hFF00, 16'h0020 + 16'(i), "wrap_pop");
        rd_chk(16'hFF03, 16'h0000, "wrap_count_0");

`ifdef IO_RESPONDER_TIMEOUT_EN
        wr_do(16'hFF01, 16'h1234, "tmo_wr_1234");
        req = 1'b1; we = 1'b1; addr = 16'hFF01; wdata = 16'h5678;
        lat = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (ack) begin
                lat = i;
                break;
            end
        end
        req = 1'b0;
        tick();
        tick();
        chk("tmo_latency", lat, 257);
        chk("tmo_out_data_kept", out_data, 16'h1234);
        rd_chk(16'hFF02, 16'h001C, "tmo_status");
        wr_do(16'hFF02, 16'h0018, "tmo_clear");
        rd_chk(16'hFF02, 16'h000C, "tmo_status_cleared");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
